muldiv_unit: RTL

- Iterative multi-cycle RV32M multiply/divide unit in the EX stage, alongside the single-cycle ALU.
- The pipeline issues an operation with a start/busy/done handshake.
- The hazard unit stalls on busy; the result and ZF are returned to the EX/MEM mux.
- One multiplier bit or quotient bit is produced per cycle (radix-2 shift-add / restoring divide).

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the iterative RV32M multiply/divide unit
package muldiv_pkg;
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;
  function automatic int cnt_width(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
  localparam int CNT_W = cnt_width(32);
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 shift-add multiply / restoring divide, one bit per cycle
// ports: clk, rst (async active-low), start/op/A/B request, busy/done handshake,
//        res held until the next completion, ZF = res is zero
module muldiv_unit import muldiv_pkg::*; #(
  parameter int bit_width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           op,
  input  logic [bit_width-1:0] A,
  input  logic [bit_width-1:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [bit_width-1:0] res,
  output logic                 ZF
);
  localparam int w = bit_width;
  localparam int cw = cnt_width(bit_width);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [cw-1:0] cnt_q, cnt_d;
  logic [2*w-1:0] acc_q, acc_d;
  logic [w-1:0] rem_q, rem_d, b_q, b_d, res_q, res_d;
  logic neg_q, neg_d, rneg_q, rneg_d, done_q, done_d;
  op_e op_in;
  logic a_neg, b_neg, div_zero, div_ovf;
  logic [w-1:0] abs_a, abs_b;
  logic [w:0] mul_sum, rem_sh, diff;
  logic [2*w-1:0] prod;
  logic [w-1:0] quot, remv, res_fix;
  always_comb begin
    op_in = op_e'(op);
    a_neg = A[w-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    b_neg = B[w-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    abs_a = a_neg ? -A : A;
    abs_b = b_neg ? -B : B;
    div_zero = op[2] & (B == '0);
    div_ovf = (op_in inside {OP_DIV, OP_REM}) & (A == {1'b1, {(w-1){1'b0}}}) & (&B);
    // multiply: add multiplicand into the high half when the low bit is set, then shift right
    mul_sum = {1'b0, acc_q[2*w-1:w]} + (acc_q[0] ? {1'b0, b_q} : '0);
    // divide: the w+1 bit partial remainder decides the quotient bit by its sign
    rem_sh = {rem_q, acc_q[w-1]};
    diff = rem_sh - {1'b0, b_q};
    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -acc_q[w-1:0] : acc_q[w-1:0];
    remv = rneg_q ? -rem_q : rem_q;
    res_fix = op_q == OP_MUL ? prod[w-1:0] : !op_q[2] ? prod[2*w-1:w] : !op_q[1] ? quot : remv;
  end
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    acc_d = acc_q;
    rem_d = rem_q;
    b_d = b_q;
    neg_d = neg_q;
    rneg_d = rneg_q;
    res_d = res_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        op_d = op_in;
        b_d = abs_b;
        cnt_d = cw'(w - 1);
        acc_d = {{w{1'b0}}, abs_a};
        rem_d = '0;
        neg_d = a_neg ^ b_neg;
        rneg_d = a_neg;
        state_d = S_CALC;
        // fast paths preload the final values and neutralise the sign fix
        if (div_zero || div_ovf) begin
          acc_d = {{w{1'b0}}, div_zero ? {w{1'b1}} : A};
          rem_d = div_zero ? A : '0;
          neg_d = 1'b0;
          rneg_d = 1'b0;
          state_d = S_FIX;
        end
      end
      S_CALC: begin
        acc_d = op_q[2] ? {acc_q[2*w-1:w], acc_q[w-2:0], ~diff[w]} : {mul_sum, acc_q[w-1:1]};
        rem_d = op_q[2] ? (diff[w] ? rem_sh[w-1:0] : diff[w-1:0]) : rem_q;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_q == '0 ? S_FIX : S_CALC;
      end
      S_FIX: begin
        res_d = res_fix;
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q <= OP_MUL;
      cnt_q <= '0;
      acc_q <= '0;
      rem_q <= '0;
      b_q <= '0;
      neg_q <= 1'b0;
      rneg_q <= 1'b0;
      res_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      rem_q <= rem_d;
      b_q <= b_d;
      neg_q <= neg_d;
      rneg_q <= rneg_d;
      res_q <= res_d;
      done_q <= done_d;
    end
  end
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign res = res_q;
  assign ZF = ~(|res_q);
endmodule
